// File: rtl/rst_seq_x1.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq_x1
//  Purpose  : Reset sequencer. Turns the asynchronous active-low chip reset
//             into NDOM staged, clock-synchronous active-low reset releases.
//             The tie-high net is the D input of the synchroniser chain, so
//             reset assertion is immediate and deassertion is synchronised,
//             stretched and released one domain at a time, GAP cycles apart.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    ck        in   clock
//    nrst      in   asynchronous active-low reset
//    one       in   tie-high net, data input of the synchroniser chain
//    swrst     in   synchronous software reset request (active high)
//    nrst_out  out  [NDOM] per-domain active-low reset, bit 0 released first
//    ready     out  high once every domain is released
//    busy      out  high while stretching or releasing
// ============================================================================
module rst_seq_x1 #(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int NDOM        = 3,
    parameter int GAP         = 4
) (
    input  logic            ck,
    input  logic            nrst,
    input  logic            one,
    input  logic            swrst,
    output logic [NDOM-1:0] nrst_out,
    output logic            ready,
    output logic            busy
);

    localparam int C_MAXCNT = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int C_CNT_W  = $clog2(C_MAXCNT) + 1;

    localparam logic [C_CNT_W-1:0] C_STRETCH_LAST = C_CNT_W'(STRETCH - 1);
    localparam logic [C_CNT_W-1:0] C_GAP_LAST     = C_CNT_W'(GAP - 1);
    localparam logic [NDOM-1:0]    C_FIRST_DOM    = NDOM'(1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STRETCH = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [C_CNT_W-1:0]      cnt_q, cnt_d;
    logic [NDOM-1:0]         nrst_out_q, nrst_out_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    synced;
    logic [NDOM-1:0]         next_mask;

    assign synced = sync_q[SYNC_STAGES-1];

    // Released domains form a contiguous run of ones from bit 0, so the next
    // domain is released by shifting in another one from the bottom.
    assign next_mask = (nrst_out_q << 1) | C_FIRST_DOM;

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            sync_q     <= '0;
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            nrst_out_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], one};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nrst_out_q <= nrst_out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nrst_out_d = nrst_out_q;
        ready_d    = ready_q;
        busy_d     = busy_q;

        if (state_q == S_HOLD) begin
            nrst_out_d = '0;
            ready_d    = 1'b0;
            busy_d     = 1'b0;
            cnt_d      = '0;
            if (synced) begin
                state_d = S_STRETCH;
                busy_d  = 1'b1;
            end
        end else if (!synced) begin
            // Losing the tie-high net outranks a software reset request.
            state_d    = S_HOLD;
            cnt_d      = '0;
            nrst_out_d = '0;
            ready_d    = 1'b0;
            busy_d     = 1'b0;
        end else if (swrst) begin
            state_d    = S_STRETCH;
            cnt_d      = '0;
            nrst_out_d = '0;
            ready_d    = 1'b0;
            busy_d     = 1'b1;
        end else begin
            case (state_q)
                S_STRETCH: begin
                    if (cnt_q == C_STRETCH_LAST) begin
                        cnt_d      = '0;
                        nrst_out_d = C_FIRST_DOM;
                        if (NDOM == 1) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == C_GAP_LAST) begin
                        cnt_d      = '0;
                        nrst_out_d = next_mask;
                        if (next_mask[NDOM-1]) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    // S_RUN: outputs hold until a reset of some kind.
                end
            endcase
        end
    end

    assign nrst_out = nrst_out_q;
    assign ready    = ready_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_x1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_seq_x1
//  Purpose  : Directed bench for rst_seq_x1 (default parameters plus a
//             minimal NDOM=1 / STRETCH=1 / GAP=1 / SYNC_STAGES=3 instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rst_seq_x1;

    logic       ck;
    logic       nrst, one, swrst;
    logic [2:0] nrst_out;
    logic       ready, busy;

    logic       nrst2, one2, swrst2;
    logic [0:0] nrst_out2;
    logic       ready2, busy2;

    int nvec  = 0;
    int nfail = 0;

    rst_seq_x1 dut (
        .ck       (ck),
        .nrst     (nrst),
        .one      (one),
        .swrst    (swrst),
        .nrst_out (nrst_out),
        .ready    (ready),
        .busy     (busy)
    );

    rst_seq_x1 #(
        .SYNC_STAGES (3),
        .STRETCH     (1),
        .NDOM        (1),
        .GAP         (1)
    ) dut_min (
        .ck       (ck),
        .nrst     (nrst2),
        .one      (one2),
        .swrst    (swrst2),
        .nrst_out (nrst_out2),
        .ready    (ready2),
        .busy     (busy2)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic       one;
        logic       swrst;
        int         n;      // edges to advance with these inputs
        logic [2:0] out;
        logic       rdy;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: {nrst_out,ready,busy} got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        // Default-instance vectors, starting right after nrst is released
        // with one=1. Edge counts are cumulative from that release.
        tbl.push_back('{1'b1, 1'b0,  2, 3'b000, 1'b0, 1'b0}); // e2
        tbl.push_back('{1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b1}); // e3 STRETCH
        tbl.push_back('{1'b1, 1'b0, 15, 3'b000, 1'b0, 1'b1}); // e18
        tbl.push_back('{1'b1, 1'b0,  1, 3'b001, 1'b0, 1'b1}); // e19
        tbl.push_back('{1'b1, 1'b0,  3, 3'b001, 1'b0, 1'b1}); // e22
        tbl.push_back('{1'b1, 1'b0,  1, 3'b011, 1'b0, 1'b1}); // e23
        tbl.push_back('{1'b1, 1'b0,  3, 3'b011, 1'b0, 1'b1}); // e26
        tbl.push_back('{1'b1, 1'b0,  1, 3'b111, 1'b1, 1'b0}); // e27 RUN
        tbl.push_back('{1'b1, 1'b0,  5, 3'b111, 1'b1, 1'b0}); // stable
        // one-cycle swrst pulse sampled at edge E
        tbl.push_back('{1'b1, 1'b1,  1, 3'b000, 1'b0, 1'b1}); // E
        tbl.push_back('{1'b1, 1'b0, 15, 3'b000, 1'b0, 1'b1}); // E+15
        tbl.push_back('{1'b1, 1'b0,  1, 3'b001, 1'b0, 1'b1}); // E+16
        tbl.push_back('{1'b1, 1'b0,  7, 3'b011, 1'b0, 1'b1}); // E+23
        tbl.push_back('{1'b1, 1'b0,  1, 3'b111, 1'b1, 1'b0}); // E+24
        // swrst held high pins the block in STRETCH with cnt=0
        tbl.push_back('{1'b1, 1'b1, 20, 3'b000, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 15, 3'b000, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0,  1, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0,  8, 3'b111, 1'b1, 1'b0});
        // loss of tie-high in RUN: two sync edges, then the state edge
        tbl.push_back('{1'b0, 1'b1,  3, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 20, 3'b000, 1'b0, 1'b0}); // swrst ignored in HOLD
        // tie-high restored: full sequence restarts
        tbl.push_back('{1'b1, 1'b0,  2, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 16, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0,  8, 3'b111, 1'b1, 1'b0});

        nrst  = 1'b0; one  = 1'b0; swrst  = 1'b0;
        nrst2 = 1'b0; one2 = 1'b1; swrst2 = 1'b0;

        // Reset state, before any clock edge has occurred.
        #1;
        check("reset_state", {nrst_out, ready, busy}, 5'b00000);
        check("reset_state_min", {2'b00, nrst_out2, ready2, busy2}, 5'b00000);

        // one=0 from reset: block never leaves HOLD, swrst has no effect.
        tick(5);
        nrst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            swrst = (i % 7 == 3);
            tick(1);
            check("one_low_hold", {nrst_out, ready, busy}, 5'b00000);
        end
        swrst = 1'b0;

        // nrst low 5 cycles, then the table from the release point.
        nrst = 1'b0;
        one  = 1'b1;
        tick(5);
        check("reset_held", {nrst_out, ready, busy}, 5'b00000);
        nrst = 1'b1;
        foreach (tbl[k]) begin
            one   = tbl[k].one;
            swrst = tbl[k].swrst;
            tick(tbl[k].n);
            check($sformatf("tbl[%0d]", k), {nrst_out, ready, busy},
                  {tbl[k].out, tbl[k].rdy, tbl[k].bsy});
        end
        one   = 1'b1;
        swrst = 1'b0;

        // Async nrst pulse while in RELEASE with nrst_out=011.
        swrst = 1'b1;
        tick(1);
        swrst = 1'b0;
        tick(20);
        check("pre_async_release", {nrst_out, ready, busy}, 5'b01101);
        #2;
        nrst = 1'b0;
        #1;
        check("async_clear", {nrst_out, ready, busy}, 5'b00000);
        #1;
        nrst = 1'b1;
        tick(18);
        check("restart_e18", {nrst_out, ready, busy}, 5'b00001);
        tick(1);
        check("restart_e19", {nrst_out, ready, busy}, 5'b00101);
        tick(4);
        check("restart_e23", {nrst_out, ready, busy}, 5'b01101);
        tick(4);
        check("restart_e27", {nrst_out, ready, busy}, 5'b11110);

        // Minimal instance: bit 0 and ready rise together after edge 5.
        tick(3);
        nrst2 = 1'b1;
        tick(3);
        check("min_e3", {2'b00, nrst_out2, ready2, busy2}, 5'b00000);
        tick(1);
        check("min_e4", {2'b00, nrst_out2, ready2, busy2}, 5'b00001);
        tick(1);
        check("min_e5", {2'b00, nrst_out2, ready2, busy2}, 5'b00110);
        tick(3);
        check("min_run", {2'b00, nrst_out2, ready2, busy2}, 5'b00110);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
